// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receiver and transmitter.
// Optional feature macro: UART_RX_PARITY_EN (adds the PARITY receive state).
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
        RX_PARITY = 3'd3,
`endif
        RX_STOP   = 3'd4
    } rx_state_t;

    // Clock cycles per bit period, rounded to the nearest integer.
    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for a single asynchronous input.
// The flops reset to RST_VAL so an idle serial line reads high out of reset.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Next-state for the two-stage shift.
    always_comb begin
        meta_d = d_i;
        sync_d = meta_q;
    end

    // Synchroniser flops; the first stage may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: non-blocking assignments keep both stages sampling the
        // pre-edge values, so the chain really is two clocks deep.
        if (!rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver (8E1 with UART_RX_PARITY_EN) presenting bytes
// on a ready/valid handshake, with framing, overrun and parity error pulses.
// Optional feature macro: UART_RX_PARITY_EN.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 25_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_i,
    output logic [UART_DATA_W-1:0] m_data_o,
    output logic                   m_valid_o,
    input  logic                   m_ready_i,
    output logic                   frame_err_o,
    output logic                   overrun_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic                   parity_err_o
`endif
);

    localparam int unsigned CPB   = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned HALF  = CPB / 2;
    localparam int          CNT_W = $clog2(CPB);

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_BIT  = CNT_W'(CPB - 1);

    localparam logic [2:0] S_IDLE   = RX_IDLE;
    localparam logic [2:0] S_START  = RX_START;
    localparam logic [2:0] S_DATA   = RX_DATA;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = RX_PARITY;
`endif
    localparam logic [2:0] S_STOP   = RX_STOP;

    logic                   rx_sync;
    logic                   fall;

    logic                   rx_prev_q,   rx_prev_d;
    logic [2:0]             state_q,     state_d;
    logic [CNT_W-1:0]       cnt_q,       cnt_d;
    logic [2:0]             idx_q,       idx_d;
    logic [UART_DATA_W-1:0] shift_q,     shift_d;
    logic [UART_DATA_W-1:0] data_q,      data_d;
    logic                   valid_q,     valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   overrun_q,   overrun_d;
    logic                   par_bad;
`ifdef UART_RX_PARITY_EN
    logic                   par_q,        par_d;
    logic                   parity_err_q, parity_err_d;
`endif

    sync2 #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx_i),
        .q_o (rx_sync)
    );

    assign fall = rx_prev_q & ~rx_sync;

`ifdef UART_RX_PARITY_EN
    assign par_bad = (par_q != ^shift_q);
`else
    assign par_bad = 1'b0;
`endif

    // Receive state machine, bit counters, handshake and error pulses.
    always_comb begin
        // NOTE: every _d gets a default before the case statement so no
        // path leaves a signal unassigned and no latch is inferred.
        rx_prev_d   = rx_sync;
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d        = par_q;
        parity_err_d = 1'b0;
`endif

        if (valid_q && m_ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    if (!rx_sync) begin
                        cnt_d   = '0;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        // Line back high at mid start bit: a glitch, not a frame.
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (cnt_q == CNT_BIT) begin
                    shift_d[idx_q] = rx_sync;
                    cnt_d          = '0;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt_q == CNT_BIT) begin
                    par_d   = rx_sync;
                    cnt_d   = '0;
                    state_d = S_STOP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                if (cnt_q == CNT_BIT) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (!rx_sync) begin
                        frame_err_d = 1'b1;
                    end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
                        parity_err_d = 1'b1;
`endif
                    end else if (valid_q) begin
                        // Previous byte not yet consumed: keep it, drop the new one.
                        overrun_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset returns to an idle line with no pending byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_prev_q   <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_prev_q   <= rx_prev_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity bit capture and parity error pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            par_q        <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_q        <= par_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign m_data_o    = data_q;
    assign m_valid_o   = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver for the UART ALU datapath. It sits directly downstream of the board `rx_i` pin (iCEBreaker `TX` net) and upstream of the ALU command parser. It deserialises 8N1 frames, LSB first, into bytes and presents them on a ready/valid handshake. It also flags framing errors, overruns and, optionally, parity errors.

## Interface
- `CLK_HZ`, default 25_000_000: core clock frequency (PLL output).
- `BAUD`, default 115200: line rate.
- `clk`, input, 1: core clock; all logic on rising edge.
- `rst`, input, 1: asynchronous, active-low reset. Asserting it (low) clears all state immediately. Release is sampled on `clk`.
- `rx_i`, input, 1: raw serial line; idles high; asynchronous to `clk`.
- `m_data_o`, output, 8: received byte.
- `m_valid_o`, output, 1: `m_data_o` holds an unconsumed byte.
- `m_ready_i`, input, 1: consumer accepts the byte when `m_valid_o && m_ready_i` on a clock edge.
- `frame_err_o`, output, 1: one-cycle pulse when the stop bit samples 0.
- `overrun_o`, output, 1: one-cycle pulse when a good byte completes while `m_valid_o` is still high.
- `parity_err_o`, output, 1: present only with `UART_RX_PARITY_EN`. One-cycle pulse on a parity mismatch.

## Operation
- `rx_i` passes through a 2-flop synchroniser, then a falling-edge detect on the synchronised value.
- Bit period `CPB = round(CLK_HZ/BAUD)`, which is 217 at the defaults. Half period `HALF = CPB/2` (108).
- The state machine has states IDLE, START, DATA, STOP, plus PARITY with the macro.
  - IDLE: a synchronised falling edge loads the tick counter with 0 and moves to START.
  - START: at count `HALF-1`, sample the line.
    - Line is 0: clear the counter and the bit index, then go to DATA.
    - Line is 1 (glitch): return to IDLE with no outputs.
  - DATA: at each count `CPB-1`, sample the line into bit `idx` (LSB first), clear the counter and increment `idx`. After `idx == 7` is sampled, go to STOP (or PARITY).
  - PARITY: at `CPB-1`, sample the parity bit and go to STOP.
  - STOP: at `CPB-1`, sample the stop bit.
    - Stop = 1, no parity error, `m_valid_o` low: load `m_data_o` and set `m_valid_o`.
    - Stop = 1, no parity error, `m_valid_o` high: pulse `overrun_o`, drop the new byte and keep the old one.
    - Stop = 0: pulse `frame_err_o` and discard the byte.
    - Parity mismatch: pulse `parity_err_o` and discard the byte.
    - In every case, return to IDLE.
- The receiver re-arms in IDLE right after the stop-bit sample, so back-to-back frames are supported.
- `m_valid_o` clears on a handshake edge. It may be set again by a later frame completing on any subsequent edge.
- Handshake rules:
  - `m_data_o` is stable while `m_valid_o` is high.
  - `m_valid_o` never drops without a handshake.
- A frame that is still low after the stop sample (break condition) just stays in IDLE until the next falling edge. No repeated errors.

## Timing
- Reset values:
  - `m_data_o`: 8'h00.
  - `m_valid_o`, `frame_err_o`, `overrun_o`, `parity_err_o`: 0.
  - State: IDLE, with counters at 0.
- Edge-detect latency is 2 clocks (synchroniser) plus 1 clock (edge register).
- Sample points from the detected edge:
  - start bit at `HALF`;
  - data bit k at `HALF + (k+1)*CPB`;
  - stop bit at `HALF + 9*CPB` (`10*CPB` with parity).
- `m_valid_o` and the error pulses assert on the clock edge that follows the stop-bit sample.
- Reset asserted mid-frame aborts the frame with no output. After release, the receiver waits for a fresh falling edge.
- Tick counter width is `$clog2(CPB)`. Bit index width is 3.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - frame becomes 8E1 (even parity after bit 7);
  - PARITY state and `parity_err_o` exist;
  - parity is computed as XOR of the 8 data bits; mismatch means the sampled bit differs from that XOR.
- `UART_RX_PARITY_EN` undefined: 8N1, with no PARITY state and no `parity_err_o` port.

## Structure
- Shared package `uart_pkg`:
  - state enum `rx_state_t`;
  - function `clks_per_bit(CLK_HZ, BAUD)` with rounding;
  - `UART_DATA_W = 8`.
- The package is also used by the future `uart_tx`.
- One sub-module, `sync2`, a 2-flop synchroniser with its reset value set to 1 (idle line).

## Test plan
- 0xA5 at 115200, `m_ready_i` low: `m_valid_o` rises about 10 bit periods after the start edge, `m_data_o = 8'hA5` and is held. Raising `m_ready_i` clears `m_valid_o` on the next edge.
- 50-cycle low glitch on an idle line: no `m_valid_o`, no error pulses, state returns to IDLE.
- 0x3C sent with the stop bit forced to 0: one `frame_err_o` pulse, `m_valid_o` stays low.
- 0x00 then 0xFF back-to-back (no idle gap), `m_ready_i` tied high: two valid beats, 8'h00 then 8'hFF, with no errors.
- 0x11 then 0x22, `m_ready_i` low: `m_data_o` stays 8'h11 and `overrun_o` pulses once at the second stop sample.
- Reset asserted at data bit 4 of 0x5A, released, then 0x81 sent: only 8'h81 is delivered. With the macro, 0x81 with the parity bit flipped gives one `parity_err_o` pulse and no valid.
